tank_vga_ctrl: RTL and testbench
================================

TANK_VGA_CTRL -- requirements
Module: tank_vga_ctrl

Interface
REQ-001 clk  in  1  50 MHz system clock; the only clock.
REQ-002 reset_n  in  1  asynchronous, active-low reset.
REQ-003 chipselect  in  1  Avalon-MM slave select.
REQ-004 write  in  1  Avalon-MM write strobe.
REQ-005 address  in  3  register index.
REQ-006 writedata  in  16  write data.
REQ-007 VGA_R, VGA_G, VGA_B  out  8 each  pixel colour.
REQ-008 VGA_CLK  out  1  25 MHz pixel clock, equal to hcount[0].
REQ-009 VGA_HS, VGA_VS  out  1 each  active-low horizontal and vertical sync.
REQ-010 VGA_BLANK_n  out  1  active-low blank.
REQ-011 VGA_SYNC_n  out  1  tied 0.

Function
REQ-012 hcount (11 b) SHALL count 0..1599 and wrap to 0; vcount (10 b) SHALL count 0..524, advancing when hcount wraps; px = hcount[10:1].
REQ-013 The block SHALL drive HS low for hcount 1312..1503 and VS low for vcount 490..491.
REQ-014 Blank SHALL apply when hcount>=1280 or vcount>=480; while blanked, BLANK_n=0 and RGB=0.
REQ-015 All VGA outputs except VGA_CLK SHALL be registered, with exactly 1 clk latency from the counter state.
REQ-016 A write occurs when chipselect=1 and write=1: the register at address is loaded with writedata on that edge.
REQ-017 Register map:
- 0 = t0x[9:0]
- 1 = t0y[9:0]
- 2 = t1x[9:0]
- 3 = t1y[9:0]
- 4 = bg[7:0]
- 5 = ctrl[0] (display enable)
- Writes to addresses 6 and 7 SHALL be ignored.
REQ-018 Tank n hit SHALL be tnx<=px<=tnx+15 and tny<=vcount<=tny+15, computed in 11-bit arithmetic with no wrap; coordinates that fall off screen SHALL simply never match.
REQ-019 Visible pixel colour priority:
- tank0 hit: 0xFF0000.
- else tank1 hit: 0x0000FF.
- else background: R=0, G=bg, B=0.
REQ-020 When ctrl[0]=0, visible RGB SHALL be 0; syncs, BLANK_n and counters are unaffected.
REQ-021 When a write and a shadow update (REQ-025) land on the same clk, the shadow SHALL take the pre-write register value; the new value appears the following frame.

Reset
REQ-022 On reset_n=0, outputs SHALL immediately and asynchronously go to: hcount=vcount=0; VGA_HS=VGA_VS=1; VGA_BLANK_n=0; RGB=0; VGA_CLK=0.
REQ-023 Reset register values: t0x=64, t0y=224, t1x=560, t1y=224, bg=0x20, ctrl[0]=1; shadow copies equal these values.
REQ-024 Reset asserted mid-line or mid-frame SHALL abort the frame; after release, timing restarts at hcount=0, vcount=0.

Configuration
REQ-025 With TANK_VGA_SHADOW_EN defined:
- Rendering SHALL use shadow copies of t0x..t1y and bg.
- Shadows load from the live registers on the clk where hcount=0 and vcount=480.
- Writes SHALL NOT alter the frame currently being drawn.
REQ-026 Without TANK_VGA_SHADOW_EN, rendering SHALL use the live registers directly, and writes take effect on the next pixel; REQ-021 does not apply.

Verification
REQ-027 Release reset, then count clocks:
- VGA_HS falls 1313 clk after release and stays low 192 clk.
- Line period is 1600 clk.
- VGA_VS is low for 3200 clk per 840000-clk frame.
REQ-028 Write t0x=100, t0y=50 (with TANK_VGA_SHADOW_EN, then wait one frame):
- Pixels px 100..115, lines 50..65 are 0xFF0000.
- px 116 on line 50 is 0x002000.
REQ-029 Write t0 and t1 both to (300,200):
- Overlap region is 0xFF0000 (tank0 wins).
- Move t1 to (308,200): px 316..323 on lines 200..215 are 0x0000FF.
REQ-030 With TANK_VGA_SHADOW_EN, write bg=0x80 at vcount=100:
- Lines 100..479 of the current frame stay G=0x20.
- Next frame shows G=0x80.
- Without the macro, G=0x80 appears within 2 clk.
REQ-031 Write ctrl=0:
- RGB=0 on all visible pixels.
- HS, VS and BLANK_n are unchanged versus a ctrl=1 run.
- Write ctrl=1 restores the image.
REQ-032 Assert reset_n=0 at hcount=700, vcount=300:
- Outputs go to REQ-022 values in the same cycle, without a clk edge.
- After release, the first HS fall is again at 1313 clk.

Source files
------------

// File: rtl/tank_vga_ctrl.sv
// ---------------------------------------------------------------------------
// tank_vga_ctrl
//   640x480 VGA renderer for a two-tank playfield.  A 50 MHz clock drives an
//   11-bit horizontal counter (two clocks per pixel, 1600 per line) and a
//   10-bit line counter (525 lines per frame).  Two 16x16 tanks and a flat
//   green background are drawn from an Avalon-MM register file.
//
// Optional build macro:
//   TANK_VGA_SHADOW_EN - when defined, rendering reads per-frame shadow copies
//                        of the tank coordinates and background that are
//                        refreshed at the start of vertical blanking, so
//                        writes never tear the frame being drawn.
//
// Ports:
//   clk          in   50 MHz system clock (only clock)
//   reset_n      in   asynchronous active-low reset
//   chipselect   in   Avalon-MM slave select
//   write        in   Avalon-MM write strobe
//   address[2:0] in   register index (0 t0x, 1 t0y, 2 t1x, 3 t1y, 4 bg, 5 ctrl)
//   writedata    in   16-bit write data
//   VGA_R/G/B    out  8-bit pixel colour (registered)
//   VGA_CLK      out  25 MHz pixel clock, equal to hcount[0]
//   VGA_HS/VS    out  active-low syncs (registered)
//   VGA_BLANK_n  out  active-low blank (registered)
//   VGA_SYNC_n   out  tied low
// ---------------------------------------------------------------------------
module tank_vga_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [15:0] writedata,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_n,
  output logic        VGA_SYNC_n
);

  localparam int          NTANK    = 2;
  localparam logic [10:0] H_LAST   = 11'd1599;
  localparam logic [10:0] H_ACTIVE = 11'd1280;
  localparam logic [10:0] HS_FIRST = 11'd1312;
  localparam logic [10:0] HS_LAST  = 11'd1503;
  localparam logic [9:0]  V_LAST   = 10'd524;
  localparam logic [9:0]  V_ACTIVE = 10'd480;
  localparam logic [9:0]  VS_FIRST = 10'd490;
  localparam logic [9:0]  VS_LAST  = 10'd491;
  localparam logic [10:0] TANK_EXT = 11'd15;

  localparam logic [9:0]  T0X_RST  = 10'd64;
  localparam logic [9:0]  T0Y_RST  = 10'd224;
  localparam logic [9:0]  T1X_RST  = 10'd560;
  localparam logic [9:0]  T1Y_RST  = 10'd224;
  localparam logic [7:0]  BG_RST   = 8'h20;

  // Counters
  logic [10:0] hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        h_wrap;

  // Live register file (index 0 = tank0, 1 = tank1)
  logic [NTANK-1:0][9:0] tx_q, tx_d;
  logic [NTANK-1:0][9:0] ty_q, ty_d;
  logic [7:0]            bg_q, bg_d;
  logic                  en_q, en_d;

  // Values actually used by the renderer (live or shadow)
  logic [NTANK-1:0][9:0] rtx;
  logic [NTANK-1:0][9:0] rty;
  logic [7:0]            rbg;

  // Rendering
  logic [9:0]       px;
  logic             visible;
  logic [NTANK-1:0] hit;

  // Registered outputs
  logic [7:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic       hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;

  // writedata[15:10] carries no register bits
  logic unused_wdata;
  assign unused_wdata = ^writedata[15:10];

  // ------------------------------------------------------------------ timing
  assign h_wrap = (hcount_q == H_LAST);

  always_comb begin
    hcount_d = h_wrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (h_wrap) begin
      vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    end
  end

  // ---------------------------------------------------------- register file
  always_comb begin
    tx_d = tx_q;
    ty_d = ty_q;
    bg_d = bg_q;
    en_d = en_q;
    if (chipselect && write) begin
      case (address)
        3'd0:    tx_d[0] = writedata[9:0];
        3'd1:    ty_d[0] = writedata[9:0];
        3'd2:    tx_d[1] = writedata[9:0];
        3'd3:    ty_d[1] = writedata[9:0];
        3'd4:    bg_d    = writedata[7:0];
        3'd5:    en_d    = writedata[0];
        default: ;  // 6 and 7 are holes in the map
      endcase
    end
  end

  // ------------------------------------------------------ render source
`ifdef TANK_VGA_SHADOW_EN
  logic [NTANK-1:0][9:0] tx_sh_q, ty_sh_q;
  logic [7:0]            bg_sh_q;
  logic                  sh_load;

  // Loading from the *_q registers means a write on this same edge is
  // deferred to the next frame's snapshot.
  assign sh_load = (hcount_q == 11'd0) && (vcount_q == V_ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_sh_q <= {T1X_RST, T0X_RST};
      ty_sh_q <= {T1Y_RST, T0Y_RST};
      bg_sh_q <= BG_RST;
    end else if (sh_load) begin
      tx_sh_q <= tx_q;
      ty_sh_q <= ty_q;
      bg_sh_q <= bg_q;
    end
  end

  assign rtx = tx_sh_q;
  assign rty = ty_sh_q;
  assign rbg = bg_sh_q;
`else
  assign rtx = tx_q;
  assign rty = ty_q;
  assign rbg = bg_q;
`endif

  // ------------------------------------------------------------ hit test
  assign px      = hcount_q[10:1];
  assign visible = (hcount_q < H_ACTIVE) && (vcount_q < V_ACTIVE);

  // 11-bit compare: tx+15 can reach 1038 without wrapping, so a tank parked
  // past the right/bottom edge simply never matches a visible pixel.
  for (genvar gi = 0; gi < NTANK; gi++) begin : g_tank
    logic [10:0] x_lo, y_lo;
    assign x_lo = {1'b0, rtx[gi]};
    assign y_lo = {1'b0, rty[gi]};
    assign hit[gi] = ({1'b0, px} >= x_lo) && ({1'b0, px} <= x_lo + TANK_EXT) &&
                     ({1'b0, vcount_q} >= y_lo) && ({1'b0, vcount_q} <= y_lo + TANK_EXT);
  end

  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (visible && en_q) begin
      if (hit[0]) begin
        r_d = 8'hFF;
      end else if (hit[1]) begin
        b_d = 8'hFF;
      end else begin
        g_d = rbg;
      end
    end
  end

  assign hs_d      = !((hcount_q >= HS_FIRST) && (hcount_q <= HS_LAST));
  assign vs_d      = !((vcount_q >= VS_FIRST) && (vcount_q <= VS_LAST));
  assign blank_n_d = visible;

  // --------------------------------------------------------------- state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount_q  <= 11'd0;
      vcount_q  <= 10'd0;
      tx_q      <= {T1X_RST, T0X_RST};
      ty_q      <= {T1Y_RST, T0Y_RST};
      bg_q      <= BG_RST;
      en_q      <= 1'b1;
      r_q       <= 8'h00;
      g_q       <= 8'h00;
      b_q       <= 8'h00;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      tx_q      <= tx_d;
      ty_q      <= ty_d;
      bg_q      <= bg_d;
      en_q      <= en_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_n = blank_n_q;
  assign VGA_CLK     = hcount_q[0];
  assign VGA_SYNC_n  = 1'b0;

endmodule

// File: tb/tb_tank_vga_ctrl.sv
`timescale 1ns/1ps
module tb_tank_vga_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic [2:0]  address = 3'd0;
  logic [15:0] writedata = 16'd0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_SYNC_n;

  int tests = 0;
  int fails = 0;

`ifdef TANK_VGA_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  tank_vga_ctrl dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .write(write),
    .address(address), .writedata(writedata),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_CLK(VGA_CLK),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_n(VGA_BLANK_n),
    .VGA_SYNC_n(VGA_SYNC_n)
  );

  always #10 clk = ~clk;

  // ---------------------------------------------------------------- model
  // cur_t = clocks since reset release within the frame; the screen
  // position it denotes is plain division by the line length.
  int cur_t;
  int mh, mv;
  int m_tx[2], m_ty[2], m_bg, m_en;
  int s_tx[2], s_ty[2], s_bg;
  logic [23:0] exp_rgb;
  logic exp_hs, exp_vs, exp_blank_n;
  int disp_h = -1, disp_v = -1;
  bit chk_en = 1'b0;

  function automatic logic [23:0] pixel(int h, int v, int tx0, int ty0,
                                        int tx1, int ty1, int bg, int en);
    int p;
    logic [7:0] g8;
    p  = h / 2;
    g8 = bg[7:0];
    if (h >= 1280 || v >= 480 || en == 0) return 24'h000000;
    if (p >= tx0 && p <= tx0 + 15 && v >= ty0 && v <= ty0 + 15) return 24'hFF0000;
    if (p >= tx1 && p <= tx1 + 15 && v >= ty1 && v <= ty1 + 15) return 24'h0000FF;
    return {8'h00, g8, 8'h00};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_t = 0;
      m_tx = '{64, 560}; m_ty = '{224, 224}; m_bg = 32; m_en = 1;
      s_tx = m_tx; s_ty = m_ty; s_bg = m_bg;
      exp_rgb = 24'h0; exp_hs = 1'b1; exp_vs = 1'b1; exp_blank_n = 1'b0;
      disp_h = -1; disp_v = -1;
    end else begin
      mh = cur_t % 1600;
      mv = cur_t / 1600;
      exp_hs      = !(mh >= 1312 && mh <= 1503);
      exp_vs      = !(mv == 490 || mv == 491);
      exp_blank_n = (mh < 1280 && mv < 480);
      if (SH) begin
        exp_rgb = pixel(mh, mv, s_tx[0], s_ty[0], s_tx[1], s_ty[1], s_bg, m_en);
        if (mh == 0 && mv == 480) begin
          s_tx = m_tx; s_ty = m_ty; s_bg = m_bg;
        end
      end else begin
        exp_rgb = pixel(mh, mv, m_tx[0], m_ty[0], m_tx[1], m_ty[1], m_bg, m_en);
      end
      disp_h = mh;
      disp_v = mv;
      if (chipselect && write) begin
        case (address)
          3'd0: m_tx[0] = int'(writedata[9:0]);
          3'd1: m_ty[0] = int'(writedata[9:0]);
          3'd2: m_tx[1] = int'(writedata[9:0]);
          3'd3: m_ty[1] = int'(writedata[9:0]);
          3'd4: m_bg    = int'(writedata[7:0]);
          3'd5: m_en    = int'(writedata[0]);
          default: ;
        endcase
      end
      cur_t = (cur_t + 1) % 840000;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({VGA_R, VGA_G, VGA_B} !== exp_rgb || VGA_HS !== exp_hs || VGA_VS !== exp_vs ||
          VGA_BLANK_n !== exp_blank_n || VGA_CLK !== ((cur_t % 1600) % 2 == 1) ||
          VGA_SYNC_n !== 1'b0) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t h=%0d v=%0d got rgb=%06h hs=%b vs=%b bl=%b clk=%b sy=%b exp rgb=%06h hs=%b vs=%b bl=%b clk=%0d sy=0",
                 $time, disp_h, disp_v, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_n,
                 VGA_CLK, VGA_SYNC_n, exp_rgb, exp_hs, exp_vs, exp_blank_n, (cur_t % 1600) % 2);
      end
    end
  end

  // ---------------------------------------------------------------- tasks
  task automatic check_int(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end else begin
      $display("[TB] %s = %0d ok", name, got);
    end
  endtask

  task automatic check_rgb(input string name, input logic [23:0] got, input logic [23:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%06h exp=%06h", name, got, exp);
    end else begin
      $display("[TB] %s = %06h ok", name, got);
    end
  endtask

  task automatic check_reset(input string name);
    tests++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0 || VGA_HS !== 1'b1 || VGA_VS !== 1'b1 ||
        VGA_BLANK_n !== 1'b0 || VGA_CLK !== 1'b0 || VGA_SYNC_n !== 1'b0) begin
      fails++;
      $display("FAIL %s got rgb=%06h hs=%b vs=%b bl=%b clk=%b sy=%b exp rgb=000000 hs=1 vs=1 bl=0 clk=0 sy=0",
               name, {VGA_R, VGA_G, VGA_B}, VGA_HS, VGA_VS, VGA_BLANK_n, VGA_CLK, VGA_SYNC_n);
    end else begin
      $display("[TB] %s ok", name);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #3;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(posedge clk); #3;
    chipselect = 1'b0; write = 1'b0;
    $display("[TB] write addr=%0d data=%04h", a, d);
  endtask

  // Wait until the outputs show screen position (2*px, line); bounded.
  task automatic sample_px(input int p, input int line, output logic [23:0] rgb);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(disp_h == 2 * p && disp_v == line) && n < 100000);
    rgb = (n >= 100000) ? 24'hxxxxxx : {VGA_R, VGA_G, VGA_B};
  endtask

  // Measure first HS fall after release, its width and the line period
  task automatic measure_hs(input string tag);
    int k, lowc, per;
    k = 0;
    do begin @(posedge clk); k++; @(negedge clk); end while (VGA_HS && k < 3000);
    check_int({tag, "_hs_first_fall"}, k, 1313);
    lowc = 0;
    do begin @(posedge clk); lowc++; @(negedge clk); end while (!VGA_HS && lowc < 3000);
    check_int({tag, "_hs_low_width"}, lowc, 192);
    per = lowc;
    do begin @(posedge clk); per++; @(negedge clk); end while (VGA_HS && per < 5000);
    check_int({tag, "_line_period"}, per, 1600);
  endtask

  // ------------------------------------------------------------- directed
  // Tank0 at (100,10), tank1 at (108,10): overlap px 108..115 shows tank0.
  localparam int NS = 9;
  int          spx [NS] = '{99, 100, 115, 116, 123, 124, 100, 123, 100};
  int          sln [NS] = '{10, 10, 10, 10, 10, 10, 25, 25, 26};
  logic [23:0] sexp[NS] = '{24'h002000, 24'hFF0000, 24'hFF0000, 24'h0000FF,
                            24'h0000FF, 24'h002000, 24'hFF0000, 24'h0000FF, 24'h002000};

  initial begin
    logic [23:0] rgb;
    logic [2:0]  a;
    logic [15:0] d;
    int          k;

    #1 reset_n = 1'b0;
    #2 check_reset("reset_state");
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #3 reset_n = 1'b1;
    measure_hs("boot");

    // Abort the frame mid-line with an asynchronous reset
    k = 0;
    do begin @(posedge clk); #3; k++; end while (cur_t != 1600 + 701 && k < 5000);
    reset_n = 1'b0;
    #1 check_reset("async_reset_midframe");
    @(posedge clk); #3;
    reset_n = 1'b1;
    measure_hs("rerun");

    // Directed tank placement; upper writedata bits must be ignored
    do_write(3'd0, 16'hFC00 | 16'd100);
    do_write(3'd1, 16'hA800 | 16'd10);
    do_write(3'd2, 16'd108);
    do_write(3'd3, 16'd10);
    do_write(3'd6, 16'h0000);
    do_write(3'd7, 16'h0000);
    for (int i = 0; i < NS; i++) begin
      sample_px(spx[i], sln[i], rgb);
      check_rgb($sformatf("pix_%0d_%0d", spx[i], sln[i]), rgb, SH ? 24'h002000 : sexp[i]);
    end

    // Display enable
    do_write(3'd5, 16'h0000);
    sample_px(100, 27, rgb);
    check_rgb("ctrl_off_pix", rgb, 24'h000000);
    do_write(3'd5, 16'h0001);
    sample_px(50, 28, rgb);
    check_rgb("ctrl_on_pix", rgb, 24'h002000);

    // Background change mid-line: live registers show it two clocks on
    k = 0;
    do begin @(posedge clk); #3; k++; end while (cur_t != 30 * 1600 + 200 && k < 10000);
    do_write(3'd4, 16'h0080);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check_rgb("bg_write_2clk", {VGA_R, VGA_G, VGA_B}, SH ? 24'h002000 : 24'h008000);

    // Randomized register traffic, checked every cycle by the model
    while (cur_t < 46 * 1600) begin
      repeat ($urandom_range(1, 250)) @(posedge clk);
      a = 3'($urandom_range(0, 7));
      d = 16'($urandom);
      if (a == 3'd1 || a == 3'd3) d[9:0] = 10'($urandom_range(25, 50));
      if ((a == 3'd0 || a == 3'd2) && $urandom_range(0, 3) != 0) d[9:0] = 10'($urandom_range(0, 650));
      if (a == 3'd5) d[0] = ($urandom_range(0, 3) != 0);
      do_write(a, d);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
